// File: rtl/fetch_if.sv
// Fetch-stage bundle: hazard/branch control in, instruction memory port, IF/ID register outputs.
interface fetch_if;
  logic        hazard;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;

  modport master (
    input  hazard, branch_taken, branch_addr, imem_ack, imem_rdata,
    output imem_req, imem_addr, id_pc, id_instr, id_valid
  );

  modport slave (
    output hazard, branch_taken, branch_addr, imem_ack, imem_rdata,
    input  imem_req, imem_addr, id_pc, id_instr, id_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, one outstanding imem request, IF/ID register
// with hazard freeze and branch redirect/flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus_io
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] redirect_q;
  logic [31:0] hold_instr_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_instr_q;
  logic        id_valid_q;
  logic        req_q;

  logic [31:0] target;
  logic [31:0] pc_inc;

  assign target = bus_io.branch_addr & ~32'd3;
  assign pc_inc = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      redirect_q   <= 32'd0;
      hold_instr_q <= 32'd0;
      id_pc_q      <= 32'd0;
      id_instr_q   <= 32'd0;
      id_valid_q   <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StFetch;
          req_q   <= 1'b1;
        end

        StFetch: begin
          if (bus_io.imem_ack) begin
            if (bus_io.branch_taken) begin
              pc_q       <= target;
              id_valid_q <= 1'b0;
            end else if (bus_io.hazard) begin
              // Park the returned word until ID unfreezes; no new request meanwhile.
              hold_instr_q <= bus_io.imem_rdata;
              state_q      <= StHold;
              req_q        <= 1'b0;
            end else begin
              id_instr_q <= bus_io.imem_rdata;
              id_pc_q    <= pc_inc;
              id_valid_q <= 1'b1;
              pc_q       <= pc_inc;
            end
          end else begin
            if (bus_io.branch_taken) begin
              // Request in flight must complete before the address can change.
              redirect_q <= target;
              id_valid_q <= 1'b0;
              state_q    <= StDrain;
            end else if (!bus_io.hazard) begin
              id_valid_q <= 1'b0;
            end
          end
        end

        StHold: begin
          if (bus_io.branch_taken) begin
            pc_q       <= target;
            id_valid_q <= 1'b0;
            state_q    <= StFetch;
            req_q      <= 1'b1;
          end else if (!bus_io.hazard) begin
            id_instr_q <= hold_instr_q;
            id_pc_q    <= pc_inc;
            id_valid_q <= 1'b1;
            pc_q       <= pc_inc;
            state_q    <= StFetch;
            req_q      <= 1'b1;
          end
        end

        StDrain: begin
          id_valid_q <= 1'b0;
          if (bus_io.imem_ack) begin
            pc_q    <= bus_io.branch_taken ? target : redirect_q;
            state_q <= StFetch;
          end else if (bus_io.branch_taken) begin
            redirect_q <= target;
          end
        end

        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.imem_req  = req_q;
  assign bus_io.imem_addr = pc_q;
  assign bus_io.id_pc     = id_pc_q;
  assign bus_io.id_instr  = id_instr_q;
  assign bus_io.id_valid  = id_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected fetch addresses and IF/ID words are queued by the
// stimulus and popped by independent monitors when the DUT completes a fetch or hands off a word.
module tb_fetch_unit;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  fetch_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_instr_q[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign bus.imem_rdata = mem(bus.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Completed memory transactions, in order.
  always @(negedge clk) begin
    if (rst_n && bus.imem_req && bus.imem_ack) begin
      if (exp_addr_q.size() == 0) chk("unexpected_fetch", bus.imem_addr, 32'hDEAD_DEAD);
      else chk("fetch_addr", bus.imem_addr, exp_addr_q.pop_front());
    end
  end

  // Word accepted by ID: valid and not frozen.
  always @(negedge clk) begin
    if (rst_n && bus.id_valid && !bus.hazard) begin
      if (exp_pc_q.size() == 0) begin
        chk("unexpected_id_word", bus.id_pc, 32'hDEAD_DEAD);
      end else begin
        chk("id_pc", bus.id_pc, exp_pc_q.pop_front());
        chk("id_instr", bus.id_instr, exp_instr_q.pop_front());
      end
    end
  end

  task automatic step(input logic ack, input logic hz, input logic bt, input logic [31:0] ba);
    bus.imem_ack     = ack;
    bus.hazard       = hz;
    bus.branch_taken = bt;
    bus.branch_addr  = ba;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_fetch(input logic [31:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic exp_word(input logic [31:0] pc, input logic [31:0] a);
    exp_pc_q.push_back(pc);
    exp_instr_q.push_back(mem(a));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.imem_ack     = 1'b0;
    bus.hazard       = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_addr  = 32'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("rst_id_pc", bus.id_pc, 32'd0);
    chk("rst_id_instr", bus.id_instr, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_req", {31'd0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, 32'd0);
    chk("first_valid", {31'd0, bus.id_valid}, 32'd0);

    // Streaming fetch from reset.
    for (int i = 0; i < 4; i++) begin
      exp_fetch(32'(i * 4));
      exp_word(32'(i * 4 + 4), 32'(i * 4));
      step(1'b1, 1'b0, 1'b0, 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("bubble_valid", {31'd0, bus.id_valid}, 32'd0);

    // Hazard at pc 0x10: park the word in HOLD.
    exp_fetch(32'h10);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("hold_req0", {31'd0, bus.imem_req}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    chk("hold_req1", {31'd0, bus.imem_req}, 32'd0);
    chk("hold_id_pc", bus.id_pc, 32'h10);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    chk("hold_req2", {31'd0, bus.imem_req}, 32'd0);
    exp_word(32'h14, 32'h10);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("unhold_valid", {31'd0, bus.id_valid}, 32'd1);
    chk("unhold_id_pc", bus.id_pc, 32'h14);
    chk("unhold_id_instr", bus.id_instr, mem(32'h10));
    chk("unhold_addr", bus.imem_addr, 32'h14);

    // Branch while the request to 0x20 is pending.
    for (int i = 0; i < 3; i++) begin
      exp_fetch(32'(32'h14 + i * 4));
      exp_word(32'(32'h18 + i * 4), 32'(32'h14 + i * 4));
      step(1'b1, 1'b0, 1'b0, 32'd0);
    end
    step(1'b0, 1'b0, 1'b1, 32'h103);
    chk("drain_addr0", bus.imem_addr, 32'h20);
    chk("drain_valid0", {31'd0, bus.id_valid}, 32'd0);
    chk("drain_req", {31'd0, bus.imem_req}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk("drain_addr1", bus.imem_addr, 32'h20);
    exp_fetch(32'h20);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("redirect_addr", bus.imem_addr, 32'h100);
    chk("redirect_valid", {31'd0, bus.id_valid}, 32'd0);

    // Branch beats hazard on an acked fetch.
    exp_fetch(32'h100);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    chk("prio_addr", bus.imem_addr, 32'h200);
    chk("prio_req", {31'd0, bus.imem_req}, 32'd1);
    chk("prio_valid", {31'd0, bus.id_valid}, 32'd0);

    // Newest branch in DRAIN wins; then wrap at the top of the address space.
    step(1'b0, 1'b0, 1'b1, 32'h300);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("overwrite_addr", bus.imem_addr, 32'h200);
    exp_fetch(32'h200);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("wrap_pc", bus.imem_addr, 32'hFFFF_FFFC);
    exp_fetch(32'hFFFF_FFFC);
    exp_word(32'h0, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("wrap_id_pc", bus.id_pc, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    exp_fetch(32'h0);
    exp_word(32'h4, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h40);
    chk("pre_rst_addr", bus.imem_addr, 32'h4);

    // Asynchronous reset in DRAIN, with a stale ack after release.
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", {31'd0, bus.imem_req}, 32'd0);
    chk("async_addr", bus.imem_addr, 32'h0);
    chk("async_valid", {31'd0, bus.id_valid}, 32'd0);
    chk("async_id_pc", bus.id_pc, 32'h0);
    chk("async_id_instr", bus.id_instr, 32'h0);
    bus.branch_taken = 1'b0;
    bus.imem_ack     = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rerst_addr", bus.imem_addr, 32'h0);
    chk("rerst_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rerst_valid", {31'd0, bus.id_valid}, 32'd0);
    exp_fetch(32'h0);
    exp_word(32'h4, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);

    chk("left_fetches", 32'(exp_addr_q.size()), 32'd0);
    chk("left_words", 32'(exp_pc_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 hazard  input  1  freeze request from the hazard unit; holds PC and IF/ID outputs.
REQ-005 branch_taken  input  1  redirect request from EXE; flushes IF/ID.
REQ-006 branch_addr  input  32  redirect target; bits [1:0] ignored (treated as 00).
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  word-aligned fetch address; stable while imem_req=1 and imem_ack=0.
REQ-009 imem_ack  input  1  memory completion; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  input  32  instruction word.
REQ-011 id_pc  output  32  registered PC+4 of the instruction in id_instr.
REQ-012 id_instr  output  32  registered instruction to the ID stage.
REQ-013 id_valid  output  1  registered; 1 = id_instr is a real instruction, 0 = bubble.

Function
REQ-014 FSM states: IDLE, FETCH, HOLD, DRAIN; internal regs pc, redirect, hold_instr.
REQ-015 imem_req SHALL be 1 in FETCH and DRAIN, 0 in IDLE and HOLD; imem_addr = pc.
REQ-016 IDLE -> FETCH on the first rising edge with rst_n high; outputs unchanged.
REQ-017 FETCH, ack=1, branch_taken=1: pc<=branch_addr&~3, id_valid<=0, stay FETCH; rdata discarded.
REQ-018 FETCH, ack=1, branch_taken=0, hazard=1: hold_instr<=rdata, id_* unchanged, pc unchanged, -> HOLD.
REQ-019 FETCH, ack=1, branch_taken=0, hazard=0: id_instr<=rdata, id_pc<=pc+4, id_valid<=1, pc<=pc+4, stay FETCH.
REQ-020 FETCH, ack=0, branch_taken=1: redirect<=branch_addr&~3, id_valid<=0, pc unchanged, -> DRAIN.
REQ-021 FETCH, ack=0, branch_taken=0: pc unchanged; hazard=1 holds id_*; hazard=0 sets id_valid<=0 (bubble), id_instr/id_pc unchanged.
REQ-022 HOLD, branch_taken=1: pc<=branch_addr&~3, id_valid<=0, hold_instr discarded, -> FETCH.
REQ-023 HOLD, branch_taken=0, hazard=0: id_instr<=hold_instr, id_pc<=pc+4, id_valid<=1, pc<=pc+4, -> FETCH.
REQ-024 HOLD, branch_taken=0, hazard=1: all state held, stay HOLD.
REQ-025 DRAIN: id_valid<=0 every cycle; branch_taken=1 overwrites redirect with the newest target.
REQ-026 DRAIN, ack=1: rdata discarded, pc<=redirect (or branch_addr&~3 if branch_taken=1 that cycle), -> FETCH.
REQ-027 branch_taken SHALL take priority over hazard in every state.
REQ-028 PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0, id_pc likewise.
REQ-029 Fetch latency: ack in cycle N makes id_valid=1 visible in cycle N+1 when hazard=0 and branch_taken=0.
REQ-030 Each imem request completes exactly once; address never changes before ack.

Reset
REQ-031 rst_n low SHALL immediately force state=IDLE, pc=RESET_PC, redirect=0, hold_instr=0, id_pc=0, id_instr=0, id_valid=0, imem_req=0.
REQ-032 Reset asserted mid-request (FETCH/DRAIN) SHALL abandon the request; a late ack after rst_n release while in IDLE is ignored.
REQ-033 First request after reset release SHALL present imem_addr=RESET_PC.

Verification
REQ-034 Reset release, ack=1 every cycle, no hazard -> imem_addr 0,4,8,...; id_pc 4,8,12,... one cycle later, id_valid=1 from 2nd cycle after FETCH entry.
REQ-035 ack=1 with hazard=1 for 3 cycles at pc=0x10 -> HOLD, id_* frozen, imem_req=0 3 cycles; hazard drops -> id_instr=held word, id_pc=0x14, next imem_addr=0x14.
REQ-036 Request to 0x20 pending, branch_taken=1 target 0x103, ack 2 cycles later -> DRAIN, imem_addr stays 0x20, id_valid=0, then imem_addr=0x100.
REQ-037 branch_taken=1 and hazard=1 same cycle with ack=1 -> pc=branch target, id_valid=0, no HOLD entry.
REQ-038 pc=0xFFFF_FFFC, ack=1 -> id_pc=0, next imem_addr=0.
REQ-039 rst_n pulled low during DRAIN -> all outputs to reset values asynchronously; after release, imem_addr=RESET_PC.
